// File: rtl/lift_pkg.sv
// Shared types and constants for the 5/3 lifting row engine.
// Holds the FSM/pass enums, shift constants and boundary mirroring.
package lift_pkg;

  typedef enum logic [2:0] {
    IDLE, RD_L, RD_S, RD_R, CAP, WR, PASS_SW, FIN
  } lift_state_t;

  typedef enum logic {P, U} lift_pass_t;

  localparam int PRED_SHIFT = 1;
  localparam int UPD_SHIFT  = 2;
  localparam int UPD_ROUND  = 2;

  // Row offset of the left (right=0) or right neighbour of k,
  // folded back into the row by symmetric extension.
  function automatic logic [15:0] mirror_idx(
    input logic [15:0] k,
    input logic [15:0] len,
    input logic        right
  );
    if (!right)
      return (k == 16'd0) ? 16'd1 : k - 16'd1;
    return (k + 16'd1 >= len) ? len - 16'd2 : k + 16'd1;
  endfunction

endpackage

// File: rtl/lift_row_engine_alu.sv
// Combinational 5/3 lifting step: one predict or update sample.
// With LIFT_SAT_EN the result clamps instead of wrapping.
module lift_step_alu
  import lift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] l,
  input  logic signed [WIDTH-1:0] r,
  input  logic signed [WIDTH-1:0] s,
  input  logic                    even_odd,
  input  logic                    fwd_inv,
`ifdef LIFT_SAT_EN
  output logic                    sat,
`endif
  output logic signed [WIDTH-1:0] res
);

  localparam int EW = WIDTH + 2;

  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] corr;
  logic signed [EW-1:0] full;
  logic                 sub;

  always_comb begin
    sum = EW'(l) + EW'(r);
    if (even_odd)
      corr = sum >>> PRED_SHIFT;
    else
      corr = (sum + EW'(UPD_ROUND)) >>> UPD_SHIFT;
    // forward predict and inverse update subtract
    sub  = (even_odd == fwd_inv);
    full = sub ? EW'(s) - corr : EW'(s) + corr;
  end

`ifdef LIFT_SAT_EN
  localparam logic signed [EW-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};

  always_comb begin
    sat = 1'b0;
    res = WIDTH'(full);
    if (full > MAXV) begin
      sat = 1'b1;
      res = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (full < MINV) begin
      sat = 1'b1;
      res = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign res = WIDTH'(full);
`endif

endmodule

// File: rtl/lift_row_engine.sv
// In-place 5/3 lifting over one RAM row, forward or inverse.
// Optional LIFT_SAT_EN: saturating results and sticky sat_flag.
module lift_row_engine
  import lift_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fwd_inv,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   row_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_dv,
  output logic [ADDR_W-1:0] wr_addr,
`ifdef LIFT_SAT_EN
  output logic              sat_flag,
`endif
  output logic [WIDTH-1:0]  wr_data
);

  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] MAXL = (ADDR_W+1)'(DEPTH);

  lift_state_t state_q, state_d;
  lift_pass_t  pass_q, pass_d;
  logic        second_q, second_d;
  logic        fwd_q, fwd_d;
  logic        err_q, err_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   k_q, k_d;
  logic signed [WIDTH-1:0] l_q, l_d;
  logic signed [WIDTH-1:0] s_q, s_d;
  logic signed [WIDTH-1:0] res_q, res_d;
  logic signed [WIDTH-1:0] alu_res;
  logic [ADDR_W-1:0] a_l, a_s, a_r;
  logic len_ok;

  assign len_ok = !row_len[0] && (row_len >= TWO) && (row_len <= MAXL);

  assign a_s = base_q + ADDR_W'(k_q);
  assign a_l = base_q + ADDR_W'(mirror_idx(16'(k_q), 16'(len_q), 1'b0));
  assign a_r = base_q + ADDR_W'(mirror_idx(16'(k_q), 16'(len_q), 1'b1));

`ifdef LIFT_SAT_EN
  logic alu_sat;
  logic sat_q, sat_d;
  assign sat_flag = sat_q;
`endif

  lift_step_alu #(.WIDTH(WIDTH)) u_alu (
    .l        (l_q),
    .r        (rd_data),
    .s        (s_q),
    .even_odd (pass_q == P),
    .fwd_inv  (fwd_q),
`ifdef LIFT_SAT_EN
    .sat      (alu_sat),
`endif
    .res      (alu_res)
  );

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    second_d = second_q;
    fwd_d    = fwd_q;
    err_d    = err_q;
    base_d   = base_q;
    len_d    = len_q;
    k_d      = k_q;
    l_d      = l_q;
    s_d      = s_q;
    res_d    = res_q;
`ifdef LIFT_SAT_EN
    sat_d    = sat_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_dv    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    unique case (state_q)
      IDLE: if (start) begin
        fwd_d    = fwd_inv;
        base_d   = base_addr;
        len_d    = row_len;
        second_d = 1'b0;
        err_d    = !len_ok;
        pass_d   = fwd_inv ? P : U;
        k_d      = fwd_inv ? ONE : '0;
`ifdef LIFT_SAT_EN
        sat_d    = 1'b0;
`endif
        state_d  = len_ok ? RD_L : FIN;
      end
      RD_L: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = a_l;
        state_d = RD_S;
      end
      RD_S: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = a_s;
        l_d     = rd_data;
        state_d = RD_R;
      end
      RD_R: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = a_r;
        s_d     = rd_data;
        state_d = CAP;
      end
      CAP: begin
        busy    = 1'b1;
        res_d   = alu_res;
`ifdef LIFT_SAT_EN
        sat_d   = sat_q | alu_sat;
`endif
        state_d = WR;
      end
      WR: begin
        busy    = 1'b1;
        wr_dv   = 1'b1;
        wr_addr = a_s;
        wr_data = res_q;
        if (k_q + TWO < len_q) begin
          k_d     = k_q + TWO;
          state_d = RD_L;
        end else if (!second_q) begin
          // pass switch folded into this transition
          second_d = 1'b1;
          pass_d   = (pass_q == P) ? U : P;
          k_d      = (pass_q == P) ? '0 : ONE;
          state_d  = RD_L;
        end else begin
          state_d = FIN;
        end
      end
      PASS_SW: state_d = RD_L;
      FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pass_q   <= P;
      second_q <= 1'b0;
      fwd_q    <= 1'b0;
      err_q    <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      k_q      <= '0;
      l_q      <= '0;
      s_q      <= '0;
      res_q    <= '0;
`ifdef LIFT_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      second_q <= second_d;
      fwd_q    <= fwd_d;
      err_q    <= err_d;
      base_q   <= base_d;
      len_q    <= len_d;
      k_q      <= k_d;
      l_q      <= l_d;
      s_q      <= s_d;
      res_q    <= res_d;
`ifdef LIFT_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_lift_row_engine.sv
// Directed bench for lift_row_engine with a behavioural sample RAM.
// Build with +define+LIFT_SAT_EN to exercise the saturating variant.
module tb_lift_row_engine;

  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic reset, start, fwd_inv;
  logic [AW-1:0] base_addr;
  logic [AW:0]   row_len;
  logic busy, done, err, rd_en, wr_dv;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [WIDTH-1:0] rd_data, wr_data;
`ifdef LIFT_SAT_EN
  logic sat_flag;
`endif

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [WIDTH-1:0] ld_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wr_dv) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  lift_row_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .fwd_inv   (fwd_inv),
    .base_addr (base_addr),
    .row_len   (row_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_dv     (wr_dv),
    .wr_addr   (wr_addr),
`ifdef LIFT_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .wr_data   (wr_data)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rd(input int a);
    return int'(mem[a % DEPTH]);
  endfunction

  task automatic poke(input int a, input int v);
    ld_en   = 1'b1;
    ld_addr = AW'(a % DEPTH);
    ld_data = WIDTH'(v);
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  task automatic load4(input int b, input int v0, input int v1,
                       input int v2, input int v3);
    poke(b, v0);
    poke(b + 1, v1);
    poke(b + 2, v2);
    poke(b + 3, v3);
  endtask

  task automatic run(input bit fwd, input int b, input int len,
                     input int inj, output int bcnt, output int dcyc,
                     output int errv, output int wcnt, output int rcnt);
    fwd_inv   = fwd;
    base_addr = AW'(b);
    row_len   = (AW+1)'(len);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = 0; dcyc = -1; errv = 0; wcnt = 0; rcnt = 0;
    for (int c = 1; c < 2000; c++) begin
      if (c == inj) begin
        start     = 1'b1;
        fwd_inv   = ~fwd;
        base_addr = AW'(b + 5);
        row_len   = 7'd2;
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (wr_dv) wcnt++;
      if (rd_en) rcnt++;
      if (done) begin
        dcyc = c;
        errv = int'(err);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  int bc, dc, ev, wc, rc, diffs;

  initial begin
    reset = 1'b1; start = 1'b0; fwd_inv = 1'b0;
    base_addr = '0; row_len = '0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", int'({busy, done, err, rd_en, wr_dv}), 0);
    check("reset_bus", int'({rd_addr, wr_addr, wr_data}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    load4(0, 216, 215, 216, 217);
    run(1'b1, 0, 4, 0, bc, dc, ev, wc, rc);
    check("fwd_busy", bc, 20);
    check("fwd_done", dc, 21);
    check("fwd_err", ev, 0);
    check("fwd_wr", wc, 4);
    check("fwd_rd", rc, 12);
    check("fwd_m0", rd(0), 216);
    check("fwd_m1", rd(1), -1);
    check("fwd_m2", rd(2), 216);
    check("fwd_m3", rd(3), 1);

    run(1'b0, 0, 4, 0, bc, dc, ev, wc, rc);
    check("inv_done", dc, 21);
    check("inv_m0", rd(0), 216);
    check("inv_m1", rd(1), 215);
    check("inv_m2", rd(2), 216);
    check("inv_m3", rd(3), 217);

    for (int i = 0; i < 64; i++) poke(i, 55 + i);
    run(1'b1, 0, 64, 0, bc, dc, ev, wc, rc);
    check("ramp_busy", bc, 320);
    check("ramp_done", dc, 321);
    check("ramp_f1", rd(1), 0);
    check("ramp_f63", rd(63), 1);
    check("ramp_f0", rd(0), 55);
    check("ramp_f62", rd(62), 117);
    run(1'b0, 0, 64, 0, bc, dc, ev, wc, rc);
    diffs = 0;
    for (int i = 0; i < 64; i++)
      if (rd(i) != 55 + i) diffs++;
    check("ramp_rt", diffs, 0);

    load4(20, 32767, -32768, 32767, -32768);
    run(1'b1, 20, 4, 0, bc, dc, ev, wc, rc);
`ifdef LIFT_SAT_EN
    check("sat_m1", rd(21), -32768);
    check("sat_flag", int'(sat_flag), 1);
`else
    check("wrap_m1", rd(21), 1);
`endif

    for (int i = 0; i < 8; i++) poke(10 + i, 100);
    run(1'b1, 10, 8, 0, bc, dc, ev, wc, rc);
    diffs = 0;
    for (int i = 0; i < 8; i++)
      if (rd(10 + i) != ((i % 2 == 1) ? 0 : 100)) diffs++;
    check("const_row", diffs, 0);
`ifdef LIFT_SAT_EN
    check("sat_clr", int'(sat_flag), 0);
`endif

    run(1'b1, 0, 5, 0, bc, dc, ev, wc, rc);
    check("len5_done", dc, 1);
    check("len5_err", ev, 1);
    check("len5_io", wc + rc + bc, 0);
    run(1'b1, 0, 0, 0, bc, dc, ev, wc, rc);
    check("len0_done", dc, 1);
    check("len0_err", ev, 1);
    check("len0_io", wc + rc + bc, 0);
    run(1'b1, 0, 66, 0, bc, dc, ev, wc, rc);
    check("len66_err", ev, 1);

    load4(0, 216, 215, 216, 217);
    run(1'b1, 0, 4, 7, bc, dc, ev, wc, rc);
    check("ign_busy", bc, 20);
    check("ign_done", dc, 21);
    check("ign_m1", rd(1), -1);
    check("ign_m3", rd(3), 1);

    load4(30, 216, 215, 216, 217);
    fwd_inv = 1'b1; base_addr = 6'd30; row_len = 7'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", int'({busy, wr_dv, done}), 0);
    reset = 1'b0;
    wc = 0;
    repeat (10) begin
      if (wr_dv || busy) wc++;
      @(posedge clk); #1;
    end
    check("rst_quiet", wc, 0);
    load4(30, 216, 215, 216, 217);
    run(1'b1, 30, 4, 0, bc, dc, ev, wc, rc);
    check("rst_fresh", dc, 21);
    check("rst_m1", rd(31), -1);

    load4(62, 216, 215, 216, 217);
    run(1'b1, 62, 4, 0, bc, dc, ev, wc, rc);
    check("wrap_done", dc, 21);
    check("wrap_a62", rd(62), 216);
    check("wrap_a63", rd(63), -1);
    check("wrap_a0", rd(0), 216);
    check("wrap_a1", rd(1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
